// File: rtl/reg_file_param.sv
// Parameterised register file with per-byte writes, registered reads and an
// error pulse when a read and a write are requested on the same edge.
module reg_file_param #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 3,
  parameter logic [DATA_W-1:0] REG2_RST = 16'h0081,
  parameter logic [DATA_W-1:0] REG3_RST = 16'h0020
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                WrEn,
  input  logic                RdEn,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   WrData,
  input  logic [DATA_W/8-1:0] ByteEn,
  output logic [DATA_W-1:0]   RdData,
  output logic                RdData_Valid,
  output logic                Access_Err,
  output logic [DATA_W-1:0]   REG0,
  output logic [DATA_W-1:0]   REG1,
  output logic [DATA_W-1:0]   REG2,
  output logic [DATA_W-1:0]   REG3
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BYTE_N = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  logic wrAccept;
  logic rdAccept;
  logic conflict;

  always_comb begin
    wrAccept = WrEn & ~RdEn;
    rdAccept = RdEn & ~WrEn;
    conflict = WrEn & RdEn;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 2)      mem[i] <= REG2_RST;
        else if (i == 3) mem[i] <= REG3_RST;
        else             mem[i] <= '0;
      end
    end else if (wrAccept) begin
      for (int b = 0; b < BYTE_N; b++) begin
        if (ByteEn[b]) mem[Address][8*b +: 8] <= WrData[8*b +: 8];
      end
    end
  end

  // RdData holds between accepted reads; a conflicting request touches nothing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RdData       <= '0;
      RdData_Valid <= 1'b0;
      Access_Err   <= 1'b0;
    end else begin
      RdData_Valid <= rdAccept;
      Access_Err   <= conflict;
      if (rdAccept) RdData <= mem[Address];
    end
  end

  assign REG0 = mem[0];
  assign REG1 = mem[1];
  assign REG2 = mem[2];
  assign REG3 = mem[3];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed-vector bench for reg_file_param: each vector is driven on a falling
// edge and its registered effect is checked on the following falling edge.
module tb_reg_file_param;

  logic        CLK;
  logic        RST;
  logic        WrEn;
  logic        RdEn;
  logic [2:0]  Address;
  logic [15:0] WrData;
  logic [1:0]  ByteEn;
  logic [15:0] RdData;
  logic        RdData_Valid;
  logic        Access_Err;
  logic [15:0] REG0, REG1, REG2, REG3;

  int errors = 0;
  int checks = 0;

  reg_file_param dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
    .WrData(WrData), .ByteEn(ByteEn), .RdData(RdData),
    .RdData_Valid(RdData_Valid), .Access_Err(Access_Err),
    .REG0(REG0), .REG1(REG1), .REG2(REG2), .REG3(REG3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic        expValid;
    logic [15:0] expRd;
    logic        expErr;
    logic [15:0] expReg1;
    logic [15:0] expReg3;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [2:0] addr,
                       input logic [15:0] data, input logic [1:0] be);
    WrEn = wr; RdEn = rd; Address = addr; WrData = data; ByteEn = be;
  endtask

  initial begin
    //           name          wr  rd  addr  data      be     vld  rd        err  reg1      reg3
    vecs[0]  = '{"rd0",        0,  1,  0, 16'h0000, 2'b00, 1, 16'h0000, 0, 16'h0000, 16'h0020};
    vecs[1]  = '{"rd2",        0,  1,  2, 16'h0000, 2'b00, 1, 16'h0081, 0, 16'h0000, 16'h0020};
    vecs[2]  = '{"rd3",        0,  1,  3, 16'h0000, 2'b00, 1, 16'h0020, 0, 16'h0000, 16'h0020};
    vecs[3]  = '{"rd7",        0,  1,  7, 16'h0000, 2'b00, 1, 16'h0000, 0, 16'h0000, 16'h0020};
    vecs[4]  = '{"idle_hold",  0,  0,  2, 16'h0000, 2'b00, 0, 16'h0000, 0, 16'h0000, 16'h0020};
    vecs[5]  = '{"wr3",        1,  0,  3, 16'h0023, 2'b11, 0, 16'h0000, 0, 16'h0000, 16'h0023};
    vecs[6]  = '{"wr1",        1,  0,  1, 16'h0066, 2'b11, 0, 16'h0000, 0, 16'h0066, 16'h0023};
    vecs[7]  = '{"rd3_b2b",    0,  1,  3, 16'h0000, 2'b00, 1, 16'h0023, 0, 16'h0066, 16'h0023};
    vecs[8]  = '{"rd1_b2b",    0,  1,  1, 16'h0000, 2'b00, 1, 16'h0066, 0, 16'h0066, 16'h0023};
    vecs[9]  = '{"wr7_full",   1,  0,  7, 16'hABCD, 2'b11, 0, 16'h0066, 0, 16'h0066, 16'h0023};
    vecs[10] = '{"wr7_lo",     1,  0,  7, 16'h1234, 2'b01, 0, 16'h0066, 0, 16'h0066, 16'h0023};
    vecs[11] = '{"wr7_none",   1,  0,  7, 16'hFFFF, 2'b00, 0, 16'h0066, 0, 16'h0066, 16'h0023};
    vecs[12] = '{"rd7_merge",  0,  1,  7, 16'h0000, 2'b00, 1, 16'hAB34, 0, 16'h0066, 16'h0023};
    vecs[13] = '{"conflict5",  1,  1,  5, 16'h5555, 2'b11, 0, 16'hAB34, 1, 16'h0066, 16'h0023};
    vecs[14] = '{"after_err",  0,  0,  5, 16'h0000, 2'b00, 0, 16'hAB34, 0, 16'h0066, 16'h0023};
    vecs[15] = '{"rd5",        0,  1,  5, 16'h0000, 2'b00, 1, 16'h0000, 0, 16'h0066, 16'h0023};
    vecs[16] = '{"wr6",        1,  0,  6, 16'hBEEF, 2'b10, 0, 16'h0000, 0, 16'h0066, 16'h0023};
    vecs[17] = '{"rd6_next",   0,  1,  6, 16'h0000, 2'b00, 1, 16'hBE00, 0, 16'h0066, 16'h0023};

    RST = 1'b1;
    drive(0, 0, 0, 16'h0000, 2'b00);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_rddata", RdData, 16'h0000);
    check("rst_valid", RdData_Valid, 0);
    check("rst_err", Access_Err, 0);
    check("rst_reg0", REG0, 16'h0000);
    check("rst_reg1", REG1, 16'h0000);
    check("rst_reg2", REG2, 16'h0081);
    check("rst_reg3", REG3, 16'h0020);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].be);
      @(negedge CLK);
      check({vecs[i].name, "_valid"}, RdData_Valid, vecs[i].expValid);
      check({vecs[i].name, "_rddata"}, RdData, vecs[i].expRd);
      check({vecs[i].name, "_err"}, Access_Err, vecs[i].expErr);
      check({vecs[i].name, "_reg1"}, REG1, vecs[i].expReg1);
      check({vecs[i].name, "_reg3"}, REG3, vecs[i].expReg3);
    end

    // Reset collides with a read of addr 1 (holding 0x0066).
    drive(0, 1, 1, 16'h0000, 2'b00);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive(0, 0, 0, 16'h0000, 2'b00);
    check("rstrd_valid", RdData_Valid, 0);
    check("rstrd_rddata", RdData, 16'h0000);
    check("rstrd_reg1", REG1, 16'h0000);
    check("rstrd_reg2", REG2, 16'h0081);
    check("rstrd_reg3", REG3, 16'h0020);
    @(negedge CLK);
    check("rstrd_valid_late", RdData_Valid, 0);

    // Reset and write on the same edge: reset wins.
    drive(1, 0, 2, 16'hFFFF, 2'b11);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    drive(0, 0, 0, 16'h0000, 2'b00);
    check("rstwr_reg2", REG2, 16'h0081);

    // RST rising between edges must not disturb outputs until the next edge.
    drive(0, 1, 2, 16'h0000, 2'b00);
    @(negedge CLK);
    drive(0, 0, 0, 16'h0000, 2'b00);
    check("mid_pre_valid", RdData_Valid, 1);
    check("mid_pre_rddata", RdData, 16'h0081);
    #2 RST = 1'b1;
    #1;
    check("mid_async_valid", RdData_Valid, 1);
    check("mid_async_rddata", RdData, 16'h0081);
    @(posedge CLK);
    #1;
    check("mid_sync_valid", RdData_Valid, 0);
    check("mid_sync_rddata", RdData, 16'h0000);
    RST = 1'b0;

    // Double conflict then a clean read: error tracks each conflicting edge.
    @(negedge CLK);
    drive(1, 1, 3, 16'h1111, 2'b11);
    @(negedge CLK);
    check("dbl_err1", Access_Err, 1);
    @(negedge CLK);
    check("dbl_err2", Access_Err, 1);
    drive(0, 1, 3, 16'h0000, 2'b00);
    @(negedge CLK);
    drive(0, 0, 0, 16'h0000, 2'b00);
    check("dbl_err_clr", Access_Err, 0);
    check("dbl_rd3", RdData, 16'h0020);
    check("dbl_valid", RdData_Valid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
